mic_reg_file: RTL

- Datapath stage around the ALU: drives the B bus into the ALU and consumes the ALU result, the C bus.
- Holds the MIC-1 register set (H, OPC, TOS, CPP, LV, SP, PC, MDR, MAR, MBR).
- Owns the shifter, the N/Z flag flip-flops and the registered memory read/write/fetch strobes.
- H goes to the ALU A input; the selected B-bus register goes to the ALU B input.

---
 rtl/mic_reg_file_pkg.sv | 39 +++
 rtl/mic_reg_file_shifter.sv | 23 ++
 rtl/mic_reg_file.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mic_reg_file_pkg.sv
// Shared MIC-1 datapath definitions: widths, B-bus source codes, C-bus write bits, shifter encoding.
package mic_reg_file_pkg;

  localparam int NBITS     = 32;
  localparam int BSEL_BITS = 4;
  localparam int CWR_BITS  = 9;

  typedef enum logic [BSEL_BITS-1:0] {
    B_MDR  = 4'd0,
    B_PC   = 4'd1,
    B_MBR  = 4'd2,
    B_MBRU = 4'd3,
    B_SP   = 4'd4,
    B_LV   = 4'd5,
    B_CPP  = 4'd6,
    B_TOS  = 4'd7,
    B_OPC  = 4'd8
  } b_src_e;

  localparam int CW_H   = 0;
  localparam int CW_OPC = 1;
  localparam int CW_TOS = 2;
  localparam int CW_CPP = 3;
  localparam int CW_LV  = 4;
  localparam int CW_SP  = 5;
  localparam int CW_PC  = 6;
  localparam int CW_MDR = 7;
  localparam int CW_MAR = 8;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_SRA1 = 2'b01;
  localparam logic [1:0] SH_SLL8 = 2'b10;
  localparam logic [1:0] SH_BOTH = 2'b11;

  function automatic logic [NBITS-1:0] sext8(input logic [7:0] v);
    return {{(NBITS-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/mic_reg_file_shifter.sv
// Combinational MIC-1 shifter: turns the ALU result into the C bus (SLL8 applied before SRA1).
module mic_shifter
  import mic_reg_file_pkg::*;
(
  input  logic [NBITS-1:0] alu_c_i,
  input  logic [1:0]       shift_i,
  output logic [NBITS-1:0] c_bus_o
);

  logic [NBITS-1:0] sll8;

  always_comb begin
    sll8 = {alu_c_i[NBITS-9:0], 8'h00};
    case (shift_i)
      SH_NONE: c_bus_o = alu_c_i;
      SH_SLL8: c_bus_o = sll8;
      SH_SRA1: c_bus_o = {alu_c_i[NBITS-1], alu_c_i[NBITS-1:1]};
      SH_BOTH: c_bus_o = {sll8[NBITS-1], sll8[NBITS-1:1]};
      default: c_bus_o = alu_c_i;
    endcase
  end

endmodule

// File: rtl/mic_reg_file.sv
// MIC-1 register file, N/Z flags and registered memory strobes around the ALU.
// Optional sticky conflict_err output when MIC_RF_CONFLICT_CHECK_EN is defined.
module mic_reg_file
  import mic_reg_file_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NBITS-1:0]     alu_c,
  input  logic                 alu_n,
  input  logic                 alu_z,
  input  logic [1:0]           shift,
  input  logic [CWR_BITS-1:0]  c_wr,
  input  logic [BSEL_BITS-1:0] b_sel,
  input  logic                 mem_rd,
  input  logic                 mem_wr,
  input  logic                 mem_fetch,
  input  logic [NBITS-1:0]     mem_rdata,
  input  logic [7:0]           mem_fdata,
  output logic [NBITS-1:0]     h_out,
  output logic [NBITS-1:0]     b_bus,
  output logic                 n_flag,
  output logic                 z_flag,
  output logic [NBITS-1:0]     mem_addr,
  output logic [NBITS-1:0]     mem_wdata,
  output logic [NBITS-1:0]     mem_pc,
  output logic                 mem_rd_o,
  output logic                 mem_wr_o,
  output logic                 mem_fetch_o
`ifdef MIC_RF_CONFLICT_CHECK_EN
  ,
  output logic                 conflict_err
`endif
);

  logic [NBITS-1:0] c_bus;
  logic [NBITS-1:0] h_q, opc_q, tos_q, cpp_q, lv_q, sp_q, pc_q, mdr_q, mar_q;
  logic [NBITS-1:0] h_d, opc_d, tos_d, cpp_d, lv_d, sp_d, pc_d, mdr_d, mar_d;
  logic [7:0]       mbr_q, mbr_d;
  logic             n_q, z_q;
  logic             rd_q, wr_q, fetch_q;
  logic             rd_d, wr_d, fetch_d;

  mic_shifter u_shifter (
    .alu_c_i (alu_c),
    .shift_i (shift),
    .c_bus_o (c_bus)
  );

  // An active read strobe means its data arrives on this edge; a C-bus MDR write still wins.
  always_comb begin
    h_d     = c_wr[CW_H]   ? c_bus : h_q;
    opc_d   = c_wr[CW_OPC] ? c_bus : opc_q;
    tos_d   = c_wr[CW_TOS] ? c_bus : tos_q;
    cpp_d   = c_wr[CW_CPP] ? c_bus : cpp_q;
    lv_d    = c_wr[CW_LV]  ? c_bus : lv_q;
    sp_d    = c_wr[CW_SP]  ? c_bus : sp_q;
    pc_d    = c_wr[CW_PC]  ? c_bus : pc_q;
    mar_d   = c_wr[CW_MAR] ? c_bus : mar_q;
    mdr_d   = c_wr[CW_MDR] ? c_bus : (rd_q ? mem_rdata : mdr_q);
    mbr_d   = fetch_q ? mem_fdata : mbr_q;
    rd_d    = mem_rd & ~mem_wr;
    wr_d    = mem_wr;
    fetch_d = mem_fetch;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q     <= '0;
      opc_q   <= '0;
      tos_q   <= '0;
      cpp_q   <= '0;
      lv_q    <= '0;
      sp_q    <= '0;
      pc_q    <= '0;
      mdr_q   <= '0;
      mar_q   <= '0;
      mbr_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      fetch_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      opc_q   <= opc_d;
      tos_q   <= tos_d;
      cpp_q   <= cpp_d;
      lv_q    <= lv_d;
      sp_q    <= sp_d;
      pc_q    <= pc_d;
      mdr_q   <= mdr_d;
      mar_q   <= mar_d;
      mbr_q   <= mbr_d;
      n_q     <= alu_n;
      z_q     <= alu_z;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      fetch_q <= fetch_d;
    end
  end

  always_comb begin
    case (b_sel)
      B_MDR:   b_bus = mdr_q;
      B_PC:    b_bus = pc_q;
      B_MBR:   b_bus = sext8(mbr_q);
      B_MBRU:  b_bus = {{(NBITS-8){1'b0}}, mbr_q};
      B_SP:    b_bus = sp_q;
      B_LV:    b_bus = lv_q;
      B_CPP:   b_bus = cpp_q;
      B_TOS:   b_bus = tos_q;
      B_OPC:   b_bus = opc_q;
      default: b_bus = '0;
    endcase
  end

  assign h_out       = h_q;
  assign n_flag      = n_q;
  assign z_flag      = z_q;
  assign mem_addr    = mar_q;
  assign mem_wdata   = mdr_q;
  assign mem_pc      = pc_q;
  assign mem_rd_o    = rd_q;
  assign mem_wr_o    = wr_q;
  assign mem_fetch_o = fetch_q;

`ifdef MIC_RF_CONFLICT_CHECK_EN
  logic conflict_q, conflict_d;

  always_comb begin
    conflict_d = conflict_q
               | (rd_q & c_wr[CW_MDR])
               | (mem_rd & mem_wr)
               | (b_sel > BSEL_BITS'(B_OPC));
  end

  always_ff @(posedge clk) begin
    if (reset) conflict_q <= 1'b0;
    else       conflict_q <= conflict_d;
  end

  assign conflict_err = conflict_q;
`endif

endmodule
